// File: rtl/uart_rx_word_packer_pkg.sv
// Shared definitions for the UART receive / word packing slice.
//   - parity mode codes (PARITY parameter values)
//   - receiver FSM state encodings
//   - byte_lane(): maps a byte arrival index onto a word lane
package uart_rx_word_packer_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Arrival index idx lands in lane idx (LSB-first) or lane nb-1-idx (MSB-first).
   function automatic int unsigned byte_lane(input int unsigned idx,
                                             input int unsigned nb,
                                             input bit          msb_first);
      return msb_first ? (nb - 1 - idx) : idx;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: 2-FF rx synchroniser, baud counter, frame FSM, error detect.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   rx           raw serial input, idle high
//   byte_done    1-cycle pulse: byte_data holds a clean byte (good stop, good parity)
//   byte_data    received byte, valid with byte_done
//   frame_err    1-cycle pulse: stop bit sampled low
//   parity_err   1-cycle pulse: parity mismatch (reported at the stop-bit sample)
module uart_rx_core
   import uart_rx_word_packer_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int PARITY   = PARITY_NONE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_done,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int BIT_CYC  = CLK_FREQ / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CNT_W    = $clog2(BIT_CYC + 1);

   logic             rx_meta_q, rx_s_q, rx_prev_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_err_q, par_err_d;
   logic             half_hit, full_hit, stop_sample;

   assign half_hit    = (cnt_q == CNT_W'(HALF_CYC - 1));
   assign full_hit    = (cnt_q == CNT_W'(BIT_CYC - 1));
   assign stop_sample = (state_q == ST_STOP) && full_hit;

   // Synchroniser flops come out of reset at the idle level so that releasing
   // reset never looks like a falling edge (a phantom start bit).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchroniser chain into one stage.
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_err_q <= par_err_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that skips an assignment would otherwise infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_err_d = par_err_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s_q) state_d = ST_START;
         end
         ST_START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (half_hit) begin
               cnt_d     = '0;
               bit_d     = '0;
               par_err_d = 1'b0;
               state_d   = rx_s_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (full_hit) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (full_hit) begin
               cnt_d = '0;
               if (PARITY == PARITY_ODD)       par_err_d = ~(^shift_q ^ rx_s_q);
               else if (PARITY == PARITY_EVEN) par_err_d = ^shift_q ^ rx_s_q;
               else                            par_err_d = 1'b0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (full_hit) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign byte_done  = stop_sample && rx_s_q && !par_err_q;
   assign byte_data  = shift_q;
   assign frame_err  = stop_sample && !rx_s_q;
   assign parity_err = stop_sample && par_err_q;

endmodule

// File: rtl/uart_rx_word_packer.sv
// UART receiver plus byte-to-word packer feeding the SDRAM write FIFO.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   rx           UART serial input, idle high
//   flush        level: emit a partial word once the output register is free
//   word_data    packed word, unused lanes zero
//   word_bytes   number of valid bytes in word_data
//   word_valid   held until word_ready (transfer = valid & ready)
//   word_ready   downstream accept
//   frame_err    1-cycle pulse, stop bit low
//   parity_err   1-cycle pulse, parity mismatch
//   overrun      1-cycle pulse, completed word dropped because output was busy
module uart_rx_word_packer
   import uart_rx_word_packer_pkg::*;
#(
   parameter  int CLK_FREQ  = 50_000_000,
   parameter  int BAUD      = 9600,
   parameter  int DATA_W    = 16,
   parameter  int PARITY    = PARITY_NONE,
   parameter  int MSB_FIRST = 0,
   localparam int NB        = DATA_W / 8,
   localparam int BYTES_W   = $clog2(NB) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   input  logic               flush,
   output logic [DATA_W-1:0]  word_data,
   output logic [BYTES_W-1:0] word_bytes,
   output logic               word_valid,
   input  logic               word_ready,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overrun
);

   logic        byte_done;
   logic [7:0]  byte_data;

   uart_rx_core #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .PARITY   (PARITY)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .byte_done  (byte_done),
      .byte_data  (byte_data),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   logic [DATA_W-1:0]  pack_q, pack_d, word_q, word_d;
   logic [BYTES_W-1:0] idx_q, idx_d, bytes_q, bytes_d;
   logic               valid_q, valid_d, overrun_q, overrun_d;
   logic               full, out_free, flush_go, load;
   int unsigned        lane_sel;

   assign full     = (idx_q == BYTES_W'(NB));
   // The output register counts as free when it is empty or being drained this cycle.
   assign out_free = !valid_q || word_ready;
   // A byte arriving in the same cycle wins; flush is seen again next cycle.
   assign flush_go = flush && (idx_q != '0) && !full && !byte_done && out_free;
   assign load     = (full && out_free) || flush_go;
   assign lane_sel = byte_lane(32'(idx_q), NB, MSB_FIRST != 0);

   always_comb begin
      pack_d    = pack_q;
      idx_d     = idx_q;
      word_d    = word_q;
      bytes_d   = bytes_q;
      valid_d   = valid_q && !word_ready;
      overrun_d = 1'b0;
      if (load) begin
         word_d  = pack_q;
         bytes_d = idx_q;
         valid_d = 1'b1;
      end
      // A full word is always retired from the packer, loaded or dropped.
      if (full || flush_go) begin
         pack_d    = '0;
         idx_d     = '0;
         overrun_d = full && !out_free;
      end
      if (byte_done && !full) begin
         pack_d[lane_sel*8 +: 8] = byte_data;
         idx_d                   = idx_q + BYTES_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the pack register is reset, not left unknown: lanes a partial flush does not fill must read as zero.
         pack_q    <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         bytes_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pack_q    <= pack_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         bytes_q   <= bytes_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign word_data  = word_q;
   assign word_bytes = bytes_q;
   assign word_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: two instances at a fast baud rate.
//   inst 0 (a): DATA_W=16, LSB-first, no parity
//   inst 1 (b): DATA_W=32, MSB-first, even parity
module tb_uart_rx_word_packer;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int BIT_CYC  = CLK_FREQ / BAUD;
   localparam int NB_A     = 2;
   localparam int NB_B     = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_a = 1'b1, rx_b = 1'b1;
   logic        flush = 1'b0;
   logic        ready_a = 1'b1, ready_b = 1'b1;
   logic [15:0] a_data;
   logic [1:0]  a_bytes;
   logic        a_valid, a_ferr, a_perr, a_ovr;
   logic [31:0] b_data;
   logic [2:0]  b_bytes;
   logic        b_valid, b_ferr, b_perr, b_ovr;

   always #5 clk = ~clk;

   uart_rx_word_packer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(16),
                         .PARITY(0), .MSB_FIRST(0)) u_a (
      .clk(clk), .rst(rst), .rx(rx_a), .flush(flush),
      .word_data(a_data), .word_bytes(a_bytes), .word_valid(a_valid),
      .word_ready(ready_a), .frame_err(a_ferr), .parity_err(a_perr), .overrun(a_ovr));

   uart_rx_word_packer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(32),
                         .PARITY(2), .MSB_FIRST(1)) u_b (
      .clk(clk), .rst(rst), .rx(rx_b), .flush(flush),
      .word_data(b_data), .word_bytes(b_bytes), .word_valid(b_valid),
      .word_ready(ready_b), .frame_err(b_ferr), .parity_err(b_perr), .overrun(b_ovr));

   typedef struct { logic [63:0] data; int bytes; } word_t;

   word_t      got_a[$], got_b[$], exp_a[$], exp_b[$];
   logic [7:0] pend_a[$], pend_b[$];
   int         cnt_ferr[2], cnt_perr[2], cnt_ovr[2];
   int         exp_ferr[2], exp_perr[2], exp_ovr[2];
   int         total = 0;
   int         bad   = 0;

   // Monitor: record transfers and error pulses away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_valid && ready_a) got_a.push_back('{64'(a_data), int'(a_bytes)});
         if (b_valid && ready_b) got_b.push_back('{64'(b_data), int'(b_bytes)});
         cnt_ferr[0] += int'(a_ferr);
         cnt_perr[0] += int'(a_perr);
         cnt_ovr[0]  += int'(a_ovr);
         cnt_ferr[1] += int'(b_ferr);
         cnt_perr[1] += int'(b_perr);
         cnt_ovr[1]  += int'(b_ovr);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference packing: byte i of the word is weighted 256**lane, where lane
   // counts up from bit 0 (inst a) or down from the top lane (inst b).
   function automatic logic [63:0] model_word(input int inst);
      logic [63:0] w;
      logic [7:0]  b;
      int          k, lane;
      w = '0;
      k = (inst == 0) ? pend_a.size() : pend_b.size();
      for (int i = 0; i < k; i++) begin
         b    = (inst == 0) ? pend_a[i] : pend_b[i];
         lane = (inst == 0) ? i : (NB_B - 1 - i);
         w    = w + (64'(b) << (8 * lane));
      end
      return w;
   endfunction

   task automatic model_accept(input int inst, input logic [7:0] d);
      if (inst == 0) begin
         pend_a.push_back(d);
         if (pend_a.size() == NB_A) begin
            exp_a.push_back('{model_word(0), NB_A});
            pend_a.delete();
         end
      end else begin
         pend_b.push_back(d);
         if (pend_b.size() == NB_B) begin
            exp_b.push_back('{model_word(1), NB_B});
            pend_b.delete();
         end
      end
   endtask

   task automatic model_flush();
      if (pend_a.size() > 0) exp_a.push_back('{model_word(0), pend_a.size()});
      if (pend_b.size() > 0) exp_b.push_back('{model_word(1), pend_b.size()});
      pend_a.delete();
      pend_b.delete();
   endtask

   task automatic put_bit(input int inst, input logic v);
      if (inst == 0) rx_a = v;
      else           rx_b = v;
      repeat (BIT_CYC) @(posedge clk);
      #1;
   endtask

   // One frame, then one idle bit; the model is updated from the frame rules.
   task automatic send_frame(input int inst, input logic [7:0] d,
                             input logic par, input logic stop);
      bit has_par, par_ok;
      has_par = (inst == 1);
      put_bit(inst, 1'b0);
      for (int i = 0; i < 8; i++) put_bit(inst, d[i]);
      if (has_par) put_bit(inst, par);
      put_bit(inst, stop);
      put_bit(inst, 1'b1);
      par_ok = !has_par || ((($countones(d) + int'(par)) % 2) == 0);
      if (!stop)  exp_ferr[inst]++;
      if (!par_ok) exp_perr[inst]++;
      if (stop && par_ok) model_accept(inst, d);
   endtask

   task automatic good_frame(input int inst, input logic [7:0] d);
      send_frame(inst, d, ^d, 1'b1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (4) @(posedge clk); #1;
      model_flush();
   endtask

   task automatic check_words(input int inst, input string tag);
      word_t g, e;
      int    ng, ne, n;
      ng = (inst == 0) ? got_a.size() : got_b.size();
      ne = (inst == 0) ? exp_a.size() : exp_b.size();
      chk({tag, " word count"}, 64'(ng), 64'(ne));
      n = (ng < ne) ? ng : ne;
      for (int i = 0; i < n; i++) begin
         if (inst == 0) begin g = got_a.pop_front(); e = exp_a.pop_front(); end
         else           begin g = got_b.pop_front(); e = exp_b.pop_front(); end
         chk({tag, " word data"}, g.data, e.data);
         chk({tag, " word bytes"}, 64'(g.bytes), 64'(e.bytes));
      end
      if (inst == 0) begin got_a.delete(); exp_a.delete(); end
      else           begin got_b.delete(); exp_b.delete(); end
   endtask

   task automatic check_counts(input int inst, input string tag);
      chk({tag, " frame_err pulses"},  64'(cnt_ferr[inst]), 64'(exp_ferr[inst]));
      chk({tag, " parity_err pulses"}, 64'(cnt_perr[inst]), 64'(exp_perr[inst]));
      chk({tag, " overrun pulses"},    64'(cnt_ovr[inst]),  64'(exp_ovr[inst]));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " a outputs"}, {a_data, a_bytes, a_valid, a_ferr, a_perr, a_ovr}, '0);
      chk({tag, " b outputs"}, {b_data, b_bytes, b_valid, b_ferr, b_perr, b_ovr}, '0);
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;
      logic [63:0] held;

      // Reset state
      repeat (3) @(posedge clk); #1;
      check_idle_outputs("in reset");
      rst = 1'b0;
      repeat (3 * BIT_CYC) @(posedge clk); #1;
      check_idle_outputs("after reset");

      // LSB-first 16-bit word
      good_frame(0, 8'h34);
      good_frame(0, 8'h12);
      check_words(0, "lsb 0x1234");
      check_counts(0, "lsb 0x1234");

      // MSB-first 32-bit word with even parity
      good_frame(1, 8'h01);
      good_frame(1, 8'h02);
      good_frame(1, 8'h03);
      good_frame(1, 8'h04);
      check_words(1, "msb 0x01020304");
      check_counts(1, "msb 0x01020304");

      // Frame error then a clean word
      send_frame(0, 8'hC3, 1'b1, 1'b0);
      good_frame(0, 8'h78);
      good_frame(0, 8'h56);
      check_words(0, "after frame_err");
      check_counts(0, "after frame_err");

      // Parity error discards the byte, correct parity is accepted
      send_frame(1, 8'h01, 1'b0, 1'b1);
      check_words(1, "bad parity no word");
      send_frame(1, 8'h01, 1'b1, 1'b1);
      good_frame(1, 8'h02);
      good_frame(1, 8'h03);
      good_frame(1, 8'h04);
      check_words(1, "parity recovery");
      check_counts(1, "parity recovery");

      // Short glitch is a false start: no error, no byte
      rx_a = 1'b0;
      repeat (3) @(posedge clk); #1;
      rx_a = 1'b1;
      repeat (2 * BIT_CYC) @(posedge clk); #1;

      // Overrun: second word dropped while the first is held
      ready_a = 1'b0;
      good_frame(0, 8'hA1);
      good_frame(0, 8'hB2);
      good_frame(0, 8'hC3);
      good_frame(0, 8'hD4);
      void'(exp_a.pop_back());
      exp_ovr[0]++;
      held = exp_a[0].data;
      chk("overrun held valid", 64'(a_valid), 64'd1);
      chk("overrun held data", 64'(a_data), held);
      chk("overrun held bytes", 64'(a_bytes), 64'(NB_A));
      ready_a = 1'b1;
      repeat (4) @(posedge clk); #1;
      check_words(0, "overrun drain");
      check_counts(0, "overrun drain");

      // Partial word flush
      good_frame(0, 8'hAB);
      pulse_flush();
      check_words(0, "flush 0x00AB");
      check_words(1, "flush idle b");

      // Randomised traffic on both instances
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         s = ($urandom_range(0, 7) != 0);
         send_frame(0, d, 1'b0, s);
      end
      for (int i = 0; i < 14; i++) begin
         d = 8'($urandom);
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 7) != 0);
         send_frame(1, d, p, s);
      end
      pulse_flush();
      check_words(0, "random a");
      check_words(1, "random b");
      check_counts(0, "random a");
      check_counts(1, "random b");

      // Reset mid-byte with a partial word pending
      good_frame(0, 8'h99);
      put_bit(0, 1'b0);
      put_bit(0, 1'b1);
      put_bit(0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      check_idle_outputs("mid-frame reset");
      rx_a = 1'b1;
      pend_a.delete();
      pend_b.delete();
      rst = 1'b0;
      repeat (3 * BIT_CYC) @(posedge clk); #1;
      good_frame(0, 8'h11);
      good_frame(0, 8'h22);
      check_words(0, "after reset 0x2211");
      check_counts(0, "after reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
